lsu_mem_port: RTL and testbench

//  Initiator side of the data-memory port: accepts one load/store request at a time from the

---
 rtl/lsu_pkg.sv | 37 +++
 rtl/lsu_mem_port_if.sv | 30 +++
 rtl/lsu_lane_align.sv | 49 ++++
 rtl/lsu_mem_port.sv | 106 ++++++++++
 tb/tb_lsu_mem_port.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit memory port: width codes,
// controller states and the request legality check.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_CAPTURE,
      ST_RESP
   } lsu_state_t;

   // A faulting request never reaches the memory: bad width code, unsigned store,
   // misaligned halfword/word, or an address past the implemented memory.
   function automatic logic req_faults(input logic        store,
                                       input logic [2:0]  funct3,
                                       input logic [31:0] addr,
                                       input logic [31:0] mem_bytes);
      logic bad;
      bad = 1'b0;
      case (funct3)
         F3_B, F3_BU: bad = 1'b0;
         F3_H, F3_HU: bad = addr[0];
         F3_W:        bad = (addr[1:0] != 2'b00);
         default:     bad = 1'b1;
      endcase
      if (store && funct3[2]) bad = 1'b1;
      if (addr >= mem_bytes)  bad = 1'b1;
      return bad;
   endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// Request, response and data-memory signals of the load/store unit.
// The slave modport is the LSU's view; master is the core/memory side.
interface lsu_mem_port_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_fault;
   logic [31:0] mem_addr;
   logic [31:0] mem_din;
   logic [3:0]  mem_we;
   logic [31:0] mem_dout;

   modport slave (
      input  req_valid, req_store, req_funct3, req_addr, req_wdata, rsp_ready, mem_dout,
      output req_ready, rsp_valid, rsp_rdata, rsp_fault, mem_addr, mem_din, mem_we
   );

   modport master (
      output req_valid, req_store, req_funct3, req_addr, req_wdata, rsp_ready, mem_dout,
      input  req_ready, rsp_valid, rsp_rdata, rsp_fault, mem_addr, mem_din, mem_we
   );

endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering between the core's right-justified data and the
// 32-bit memory word, in both the store and the load direction.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  byte_off,
   input  logic [31:0] wdata,
   input  logic [31:0] mem_dout,
   output logic [3:0]  we_mask,
   output logic [31:0] mem_din,
   output logic [31:0] load_data
);

   logic [31:0] shifted;

   // Stores replicate the datum into every lane so only the enables select the target.
   always_comb begin
      we_mask = 4'b1111;
      mem_din = wdata;
      case (funct3[1:0])
         2'b00: begin
            we_mask = 4'b0001 << byte_off;
            mem_din = {4{wdata[7:0]}};
         end
         2'b01: begin
            we_mask = 4'b0011 << byte_off;
            mem_din = {2{wdata[15:0]}};
         end
         default: begin
            we_mask = 4'b1111;
            mem_din = wdata;
         end
      endcase
   end

   always_comb begin
      shifted   = mem_dout >> {byte_off, 3'b000};
      load_data = shifted;
      case (funct3)
         F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
         F3_BU:   load_data = {24'd0, shifted[7:0]};
         F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
         F3_HU:   load_data = {16'd0, shifted[15:0]};
         default: load_data = shifted;
      endcase
   end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store unit initiator port: one request at a time, a single memory
// access cycle, a capture cycle for the synchronous read, then a held response.
module lsu_mem_port
   import lsu_pkg::*;
#(
   parameter int unsigned MEM_BYTES = 804
) (
   input  logic            clk,
   input  logic            rst_n,
   lsu_mem_port_if.slave   bus
);

   lsu_state_t  state;
   logic        r_store;
   logic [2:0]  r_funct3;
   logic [1:0]  r_off;
   logic [31:0] r_wdata;
   logic [29:0] mem_word_q;
   logic        req_ready_q;
   logic        rsp_valid_q;
   logic        rsp_fault_q;
   logic [31:0] rsp_rdata_q;
   logic [3:0]  we_mask;
   logic [31:0] lane_din;
   logic [31:0] load_data;

   lsu_lane_align u_align (
      .funct3    (r_funct3),
      .byte_off  (r_off),
      .wdata     (r_wdata),
      .mem_dout  (bus.mem_dout),
      .we_mask   (we_mask),
      .mem_din   (lane_din),
      .load_data (load_data)
   );

   // Write enables come straight from state so a reset kills them immediately.
   assign bus.mem_we    = (state == ST_ACCESS && r_store) ? we_mask : 4'b0000;
   assign bus.mem_din   = lane_din;
   assign bus.mem_addr  = {mem_word_q, 2'b00};
   assign bus.req_ready = req_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_fault = rsp_fault_q;
   assign bus.rsp_rdata = rsp_rdata_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         r_store     <= 1'b0;
         r_funct3    <= F3_B;
         r_off       <= 2'b00;
         r_wdata     <= 32'd0;
         mem_word_q  <= 30'd0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_fault_q <= 1'b0;
         rsp_rdata_q <= 32'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.req_valid) begin
                  r_store     <= bus.req_store;
                  r_funct3    <= bus.req_funct3;
                  r_off       <= bus.req_addr[1:0];
                  r_wdata     <= bus.req_wdata;
                  req_ready_q <= 1'b0;
                  if (req_faults(bus.req_store, bus.req_funct3, bus.req_addr, 32'(MEM_BYTES))) begin
                     rsp_valid_q <= 1'b1;
                     rsp_fault_q <= 1'b1;
                     rsp_rdata_q <= 32'd0;
                     state       <= ST_RESP;
                  end else begin
                     mem_word_q <= bus.req_addr[31:2];
                     state      <= ST_ACCESS;
                  end
               end
            end
            ST_ACCESS: begin
               if (r_store) begin
                  rsp_valid_q <= 1'b1;
                  rsp_fault_q <= 1'b0;
                  rsp_rdata_q <= 32'd0;
                  state       <= ST_RESP;
               end else begin
                  state <= ST_CAPTURE;
               end
            end
            ST_CAPTURE: begin
               rsp_valid_q <= 1'b1;
               rsp_fault_q <= 1'b0;
               rsp_rdata_q <= load_data;
               state       <= ST_RESP;
            end
            ST_RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  state       <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port: a byte-lane memory model behind the port
// and a scoreboard of expected responses pushed as each request is driven.
module tb_lsu_mem_port;
   import lsu_pkg::*;

   typedef struct packed {
      logic [31:0] rdata;
      logic        fault;
   } exp_t;

   logic        clk;
   logic        rst_n;
   int          checks;
   int          errors;
   exp_t        sb[$];
   logic [31:0] mem_words [0:200];

   lsu_mem_port_if bus ();

   lsu_mem_port #(.MEM_BYTES(804)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous memory: byte-enabled write and one-cycle registered read.
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int w = 0; w < 201; w++) mem_words[w] <= 32'd0;
         bus.mem_dout <= 32'd0;
      end else begin
         if (bus.mem_addr[31:2] < 30'd201) begin
            for (int b = 0; b < 4; b++)
               if (bus.mem_we[b]) mem_words[bus.mem_addr[31:2]][8*b +: 8] <= bus.mem_din[8*b +: 8];
            bus.mem_dout <= mem_words[bus.mem_addr[31:2]];
         end else begin
            bus.mem_dout <= 32'd0;
         end
      end
   end

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One full transaction: drive, measure latency and memory activity, compare, handshake.
   task automatic apply_stimulus(input string tag, input logic store, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] exp_rdata, input logic exp_fault,
                                 input int exp_edges, input logic [3:0] exp_we,
                                 input logic [31:0] exp_din, input int stall);
      int          edges;
      logic [3:0]  we_seen;
      logic [31:0] din_seen;
      logic [31:0] addr_seen;
      logic [31:0] held;
      exp_t        e;
      @(posedge clk); #1;
      check_output({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
      bus.req_valid  = 1'b1;
      bus.req_store  = store;
      bus.req_funct3 = f3;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      sb.push_back('{rdata: exp_rdata, fault: exp_fault});
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      edges     = 0;
      we_seen   = 4'b0000;
      din_seen  = 32'd0;
      addr_seen = bus.mem_addr;
      while (!bus.rsp_valid && edges < 8) begin
         if (bus.mem_we != 4'b0000) begin
            we_seen  = we_seen | bus.mem_we;
            din_seen = bus.mem_din;
         end
         @(posedge clk); #1;
         edges++;
      end
      check_output({tag, "_latency"}, 32'(edges), 32'(exp_edges));
      check_output({tag, "_mem_we"}, 32'(we_seen), 32'(exp_we));
      if (store && !exp_fault) check_output({tag, "_mem_din"}, din_seen, exp_din);
      if (!exp_fault) check_output({tag, "_mem_addr"}, addr_seen, {addr[31:2], 2'b00});
      check_output({tag, "_sb_depth"}, 32'(sb.size()), 32'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check_output({tag, "_rdata"}, bus.rsp_rdata, e.rdata);
         check_output({tag, "_fault"}, 32'(bus.rsp_fault), 32'(e.fault));
      end
      held    = bus.rsp_rdata;
      we_seen = 4'b0000;
      for (int i = 0; i < stall; i++) begin
         bus.req_valid  = 1'b1;
         bus.req_store  = 1'b1;
         bus.req_funct3 = F3_W;
         bus.req_addr   = 32'h30;
         bus.req_wdata  = 32'hCAFEF00D;
         @(posedge clk); #1;
         we_seen = we_seen | bus.mem_we;
         check_output({tag, "_stall_valid"}, 32'(bus.rsp_valid), 32'd1);
         check_output({tag, "_stall_rdata"}, bus.rsp_rdata, held);
         check_output({tag, "_stall_ready"}, 32'(bus.req_ready), 32'd0);
      end
      bus.req_valid = 1'b0;
      if (stall > 0) check_output({tag, "_stall_we"}, 32'(we_seen), 32'd0);
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
      check_output({tag, "_rsp_drop"}, 32'(bus.rsp_valid), 32'd0);
   endtask

   initial begin
      checks         = 0;
      errors         = 0;
      rst_n          = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_store  = 1'b0;
      bus.req_funct3 = F3_B;
      bus.req_addr   = 32'd0;
      bus.req_wdata  = 32'd0;
      bus.rsp_ready  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_output("rst_req_ready", 32'(bus.req_ready), 32'd1);
      check_output("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check_output("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
      check_output("rst_rsp_fault", 32'(bus.rsp_fault), 32'd0);
      check_output("rst_mem_we", 32'(bus.mem_we), 32'd0);
      check_output("rst_mem_addr", bus.mem_addr, 32'd0);
      check_output("rst_mem_din", bus.mem_din, 32'd0);
      rst_n = 1'b1;

      $display("[TB] stores and loads");
      apply_stimulus("sw_10",  1'b1, F3_W,  32'h10, 32'hDEADBEEF, 32'd0, 1'b0, 1, 4'b1111, 32'hDEADBEEF, 0);
      apply_stimulus("sb_13",  1'b1, F3_B,  32'h13, 32'h000000A5, 32'd0, 1'b0, 1, 4'b1000, 32'hA5A5A5A5, 0);
      apply_stimulus("lb_13",  1'b0, F3_B,  32'h13, 32'd0, 32'hFFFFFFA5, 1'b0, 2, 4'b0000, 32'd0, 0);
      apply_stimulus("lbu_13", 1'b0, F3_BU, 32'h13, 32'd0, 32'h000000A5, 1'b0, 2, 4'b0000, 32'd0, 0);
      apply_stimulus("lw_10",  1'b0, F3_W,  32'h10, 32'd0, 32'hA5ADBEEF, 1'b0, 2, 4'b0000, 32'd0, 0);
      apply_stimulus("sh_22",  1'b1, F3_H,  32'h22, 32'h00008001, 32'd0, 1'b0, 1, 4'b1100, 32'h80018001, 0);
      apply_stimulus("lh_22",  1'b0, F3_H,  32'h22, 32'd0, 32'hFFFF8001, 1'b0, 2, 4'b0000, 32'd0, 0);
      apply_stimulus("lhu_22", 1'b0, F3_HU, 32'h22, 32'd0, 32'h00008001, 1'b0, 2, 4'b0000, 32'd0, 0);
      apply_stimulus("lw_20",  1'b0, F3_W,  32'h20, 32'd0, 32'h80010000, 1'b0, 2, 4'b0000, 32'd0, 0);
      apply_stimulus("lb_12",  1'b0, F3_B,  32'h12, 32'd0, 32'hFFFFFFAD, 1'b0, 2, 4'b0000, 32'd0, 0);

      $display("[TB] faults and range boundary");
      apply_stimulus("lw_06",  1'b0, F3_W,   32'h06,  32'd0, 32'd0, 1'b1, 0, 4'b0000, 32'd0, 0);
      apply_stimulus("lh_05",  1'b0, F3_H,   32'h05,  32'd0, 32'd0, 1'b1, 0, 4'b0000, 32'd0, 0);
      apply_stimulus("sw_400", 1'b1, F3_W,   32'h400, 32'h11223344, 32'd0, 1'b1, 0, 4'b0000, 32'd0, 0);
      apply_stimulus("lb_324", 1'b0, F3_B,   32'h324, 32'd0, 32'd0, 1'b1, 0, 4'b0000, 32'd0, 0);
      apply_stimulus("sbu_14", 1'b1, F3_BU,  32'h14,  32'h55, 32'd0, 1'b1, 0, 4'b0000, 32'd0, 0);
      apply_stimulus("f3_011", 1'b0, 3'b011, 32'h18,  32'd0, 32'd0, 1'b1, 0, 4'b0000, 32'd0, 0);
      apply_stimulus("sb_323", 1'b1, F3_B,   32'h323, 32'h0000007E, 32'd0, 1'b0, 1, 4'b1000, 32'h7E7E7E7E, 0);
      apply_stimulus("lbu_323",1'b0, F3_BU,  32'h323, 32'd0, 32'h0000007E, 1'b0, 2, 4'b0000, 32'd0, 0);

      $display("[TB] held response back-pressure");
      apply_stimulus("lh_stall", 1'b0, F3_H, 32'h22, 32'd0, 32'hFFFF8001, 1'b0, 2, 4'b0000, 32'd0, 5);
      apply_stimulus("lw_30",    1'b0, F3_W, 32'h30, 32'd0, 32'd0, 1'b0, 2, 4'b0000, 32'd0, 0);

      $display("[TB] reset during store access");
      @(posedge clk); #1;
      bus.req_valid  = 1'b1;
      bus.req_store  = 1'b1;
      bus.req_funct3 = F3_W;
      bus.req_addr   = 32'h40;
      bus.req_wdata  = 32'h12345678;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      check_output("rstmid_we_before", 32'(bus.mem_we), 32'hF);
      rst_n = 1'b0;
      #1;
      check_output("rstmid_we", 32'(bus.mem_we), 32'd0);
      check_output("rstmid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check_output("rstmid_req_ready", 32'(bus.req_ready), 32'd1);
      check_output("rstmid_mem_addr", bus.mem_addr, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_output("rstmid_idle_valid", 32'(bus.rsp_valid), 32'd0);
      check_output("rstmid_idle_ready", 32'(bus.req_ready), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
